// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation codes, register-zero index,
// datapath defaults and the ID/EX stage occupancy states.
package mips_pkg;

    localparam int unsigned XlenDefault = 32;
    localparam int unsigned RidxDefault = 5;
    localparam int unsigned RegZero     = 0;

    typedef enum logic [3:0] {
        AluAdd = 4'b0000,
        AluSub = 4'b0001,
        AluAnd = 4'b0010,
        AluOr  = 4'b0011,
        AluXor = 4'b0100,
        AluSll = 4'b0101,
        AluSrl = 4'b0110,
        AluSlt = 4'b1000,
        AluNor = 4'b1010
    } alu_funct_e;

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks EX/MEM result, then MEM/WB data, then the
// stored register value. Register zero is never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault,
    parameter int unsigned RIDX = RidxDefault
) (
    input  logic [RIDX-1:0] src,
    input  logic [XLEN-1:0] stored,
    input  logic            exm_reg_write,
    input  logic [RIDX-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd
);

    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_reg_write && (exm_rd != RIDX'(RegZero)) && (exm_rd == src);
    assign wb_hit  = wb_reg_write && (wb_rd != RIDX'(RegZero)) && (wb_rd == src);

    always_comb begin
        fwd = stored;
        if (exm_hit) begin
            fwd = exm_result;
        end else if (wb_hit) begin
            fwd = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use detection and a one-entry
// valid/ready buffer. Define ID_EX_STALL_CNT_EN to add the stall_cnt output.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault,
    parameter int unsigned RIDX = RidxDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RIDX-1:0] id_rs,
    input  logic [RIDX-1:0] id_rt,
    input  logic [RIDX-1:0] id_rd,
    input  logic [3:0]      id_funct,
    input  logic [4:0]      id_shamt,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [RIDX-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_funct,
    output logic [4:0]      alu_shamt,
    output logic [RIDX-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    stage_state_e state_q, state_d;

    logic [XLEN-1:0] rs_data_q, rs_data_d;
    logic [XLEN-1:0] rt_data_q, rt_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RIDX-1:0] rs_q, rs_d;
    logic [RIDX-1:0] rt_q, rt_d;
    logic [RIDX-1:0] rd_q, rd_d;
    logic [3:0]      funct_q, funct_d;
    logic [4:0]      shamt_q, shamt_d;
    logic            alu_src_q, alu_src_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;
    logic            advance;
    logic            rd_match;

    fwd_mux #(
        .XLEN (XLEN),
        .RIDX (RIDX)
    ) u_fwd_rs (
        .src           (rs_q),
        .stored        (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd           (fwd_rs)
    );

    fwd_mux #(
        .XLEN (XLEN),
        .RIDX (RIDX)
    ) u_fwd_rt (
        .src           (rt_q),
        .stored        (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .fwd           (fwd_rt)
    );

    assign ex_valid = (state_q == StFull);
    assign advance  = !ex_valid || ex_ready;

    // rt is always treated as a source, even for I-type consumers.
    assign rd_match       = (rd_q == id_rs) || (rd_q == id_rt);
    assign load_use_stall = ex_valid && mem_read_q && (rd_q != RIDX'(RegZero)) && rd_match
                            && in_valid;
    assign in_ready       = advance && !load_use_stall;

    always_comb begin
        state_d     = state_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        funct_d     = funct_q;
        shamt_d     = shamt_q;
        alu_src_d   = alu_src_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (flush) begin
            state_d = StEmpty;
        end else if (in_valid && in_ready) begin
            state_d     = StFull;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            funct_d     = id_funct;
            shamt_d     = id_shamt;
            alu_src_d   = id_alu_src;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end else if (advance) begin
            state_d = StEmpty;
        end else begin
            // Holding: absorb forwarded values so a producer retiring from WB
            // during the stall is not lost.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= AluAdd;
            shamt_q     <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            funct_q     <= funct_d;
            shamt_q     <= shamt_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_funct     = funct_q;
    assign alu_shamt     = shamt_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use_stall || (ex_valid && !ex_ready)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; covers stall_cnt when
// ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [3:0]  id_funct;
    logic [4:0]  id_shamt;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;
    logic        load_use_stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(
        .XLEN (32),
        .RIDX (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_funct       (id_funct),
        .id_shamt       (id_shamt),
        .id_alu_src     (id_alu_src),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .flush          (flush),
        .exm_reg_write  (exm_reg_write),
        .exm_rd         (exm_rd),
        .exm_result     (exm_result),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_funct      (alu_funct),
        .alu_shamt      (alu_shamt),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_store_data  (ex_store_data),
        .load_use_stall (load_use_stall)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid      = 1'b0;
        id_rs_data    = '0;
        id_rt_data    = '0;
        id_imm        = '0;
        id_rs         = '0;
        id_rt         = '0;
        id_rd         = '0;
        id_funct      = '0;
        id_shamt      = '0;
        id_alu_src    = 1'b0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        flush         = 1'b0;
        exm_reg_write = 1'b0;
        exm_rd        = '0;
        exm_result    = '0;
        wb_reg_write  = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        ex_ready      = 1'b1;
    endtask

    task automatic offer(input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [3:0] funct, input logic alu_src, input logic mem_read);
        in_valid     = 1'b1;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_funct     = funct;
        id_shamt     = 5'd3;
        id_alu_src   = alu_src;
        id_reg_write = 1'b1;
        id_mem_read  = mem_read;
        id_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ex_valid: got %b, expected 0", ex_valid);
        end
        n_checks++;
        if ({alu_a, alu_b, ex_store_data} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h st=%h, expected 0", alu_a, alu_b, ex_store_data);
        end
        n_checks++;
        if ({alu_funct, alu_shamt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got funct=%b shamt=%0d rd=%0d rw=%b mr=%b mw=%b, expected 0",
                     alu_funct, alu_shamt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        offer(32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_in_ready: got %b, expected 1", in_ready);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if (ex_valid !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_funct !== 4'b0000) begin
            n_fail++;
            $display("FAIL add_capture: got v=%b a=%0d b=%0d f=%b, expected v=1 a=5 b=7 f=0000",
                     ex_valid, alu_a, alu_b, alu_funct);
        end
        n_checks++;
        if (ex_rd !== 5'd3 || ex_reg_write !== 1'b1 || alu_shamt !== 5'd3) begin
            n_fail++;
            $display("FAIL add_ctrl: got rd=%0d rw=%b sh=%0d, expected rd=3 rw=1 sh=3",
                     ex_rd, ex_reg_write, alu_shamt);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drain: got ex_valid=%b, expected 0", ex_valid);
        end
    endtask

    task automatic test_forwarding();
        offer(32'hA, 32'hB, 32'h100, 5'd3, 5'd4, 5'd5, 4'b0001, 1'b1, 1'b0);
        tick();
        set_idle();
        ex_ready = 1'b0;
        #1;
        n_checks++;
        if (alu_a !== 32'hA || alu_b !== 32'h100 || ex_store_data !== 32'hB) begin
            n_fail++;
            $display("FAIL fwd_none: got a=%h b=%h st=%h, expected a=a b=100 st=b",
                     alu_a, alu_b, ex_store_data);
        end
        exm_reg_write = 1'b1;
        exm_rd        = 5'd3;
        exm_result    = 32'h11;
        wb_reg_write  = 1'b1;
        wb_rd         = 5'd3;
        wb_data       = 32'h22;
        #1;
        n_checks++;
        if (alu_a !== 32'h11) begin
            n_fail++;
            $display("FAIL fwd_exm_priority: got a=%h, expected 11", alu_a);
        end
        exm_rd = 5'd0;
        #1;
        n_checks++;
        if (alu_a !== 32'h22) begin
            n_fail++;
            $display("FAIL fwd_wb_r0_exm: got a=%h, expected 22", alu_a);
        end
        wb_rd = 5'd4;
        #1;
        n_checks++;
        if (ex_store_data !== 32'h22 || alu_b !== 32'h100 || alu_a !== 32'hA) begin
            n_fail++;
            $display("FAIL fwd_rt_store: got a=%h b=%h st=%h, expected a=a b=100 st=22",
                     alu_a, alu_b, ex_store_data);
        end
        wb_rd = 5'd0;
        exm_rd = 5'd0;
        #1;
        n_checks++;
        if (alu_a !== 32'hA || ex_store_data !== 32'hB) begin
            n_fail++;
            $display("FAIL fwd_r0_never: got a=%h st=%h, expected a=a st=b", alu_a, ex_store_data);
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        offer(32'h0, 32'h0, 32'h40, 5'd1, 5'd8, 5'd8, 4'b0000, 1'b1, 1'b1);
        tick();
        offer(32'h55, 32'h66, 32'h0, 5'd8, 5'd9, 5'd10, 4'b0011, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (ex_mem_read !== 1'b1 || load_use_stall !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_detect: got mr=%b stall=%b ready=%b, expected 1 1 0",
                     ex_mem_read, load_use_stall, in_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || load_use_stall !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%b stall=%b ready=%b, expected 0 0 1",
                     ex_valid, load_use_stall, in_ready);
        end
        tick();
        set_idle();
        #1;
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || alu_a !== 32'h55 || alu_funct !== 4'b0011) begin
            n_fail++;
            $display("FAIL lu_enter: got v=%b rd=%0d a=%h f=%b, expected 1 10 55 0011",
                     ex_valid, ex_rd, alu_a, alu_funct);
        end
        tick();
    endtask

    task automatic test_operand_refresh();
        offer(32'h1, 32'h2, 32'h0, 5'd5, 5'd4, 5'd6, 4'b0100, 1'b0, 1'b0);
        tick();
        set_idle();
        ex_ready     = 1'b0;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd4;
        wb_data      = 32'h99;
        #1;
        n_checks++;
        if (alu_b !== 32'h99) begin
            n_fail++;
            $display("FAIL refresh_c1: got b=%h, expected 99", alu_b);
        end
        tick();
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'h0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b1 || alu_b !== 32'h99) begin
            n_fail++;
            $display("FAIL refresh_c2: got v=%b b=%h, expected v=1 b=99", ex_valid, alu_b);
        end
        tick();
        n_checks++;
        if (alu_b !== 32'h99 || ex_store_data !== 32'h99 || alu_a !== 32'h1) begin
            n_fail++;
            $display("FAIL refresh_c3: got a=%h b=%h st=%h, expected a=1 b=99 st=99",
                     alu_a, alu_b, ex_store_data);
        end
        ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        offer(32'h77, 32'h78, 32'h0, 5'd11, 5'd12, 5'd13, 4'b1010, 1'b0, 1'b0);
        flush    = 1'b1;
        ex_ready = 1'b1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || alu_a !== 32'h1 || ex_rd !== 5'd6) begin
            n_fail++;
            $display("FAIL flush_no_capture: got v=%b a=%h rd=%0d, expected v=0 a=1 rd=6",
                     ex_valid, alu_a, ex_rd);
        end
        offer(32'h31, 32'h32, 32'h0, 5'd14, 5'd15, 5'd16, 4'b1000, 1'b0, 1'b0);
        tick();
        set_idle();
        ex_ready = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd16) begin
            n_fail++;
            $display("FAIL flush_over_hold: got v=%b rd=%0d, expected v=0 rd=16", ex_valid, ex_rd);
        end
        ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        set_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        // lw in EX, dependent waits: two load-use cycles, then three hold cycles
        offer(32'h0, 32'h0, 32'h8, 5'd2, 5'd8, 5'd8, 4'b0000, 1'b1, 1'b1);
        tick();
        offer(32'h44, 32'h45, 32'h0, 5'd8, 5'd3, 5'd9, 4'b0000, 1'b0, 1'b0);
        ex_ready = 1'b0;
        tick();
        ex_ready = 1'b1;
        tick();
        tick();
        set_idle();
        ex_ready = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || alu_a !== 32'h44) begin
            n_fail++;
            $display("FAIL hold_state: got v=%b rd=%0d a=%h, expected v=1 rd=9 a=44",
                     ex_valid, ex_rd, alu_a);
        end
`ifdef ID_EX_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL stall_cnt_count: got %0d, expected 5", stall_cnt);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || alu_a !== 32'h0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b a=%h rd=%0d rw=%b, expected all 0",
                     ex_valid, alu_a, ex_rd, ex_reg_write);
        end
`ifdef ID_EX_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_cnt_reset: got %0d, expected 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_empty: got v=%b, expected 0", ex_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_basic_add();
        test_forwarding();
        test_load_use();
        test_operand_refresh();
        test_flush();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
